// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand forwarding,
// load-use bubbles, memory-wait stalls with a watchdog, and a stall-cycle counter.
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       RA1_D,
  input  logic [4:0]       RA2_D,
  input  logic [4:0]       RA1_E,
  input  logic [4:0]       RA2_E,
  input  logic [4:0]       RS_E,
  input  logic             REG_WRITE_E,
  input  logic             MEM_TO_REG_E,
  input  logic [4:0]       RS_M,
  input  logic             REG_WRITE_M,
  input  logic             MEM_REQ_M,
  input  logic             MEM_READY,
  input  logic [4:0]       RS_W,
  input  logic             REG_WRITE_W,
  output logic [1:0]       FORWARD_A_E,
  output logic [1:0]       FORWARD_B_E,
  output logic             STALL_F,
  output logic             STALL_D,
  output logic             STALL_E,
  output logic             STALL_M,
  output logic             FLUSH_E,
  output logic             ERR,
  output logic [CNT_W-1:0] STALL_CYCLES
);

  localparam int WCNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [WCNT_W-1:0]   wait_cnt_r;
  logic [WCNT_W-1:0]   wait_cnt_nxt_s;
  logic                err_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                lu_s;
  logic                mem_pend_s;
  logic [1:0]          fwd_a_s;
  logic [1:0]          fwd_b_s;
  logic                stall_f_s;
  logic                stall_d_s;
  logic                stall_e_s;
  logic                stall_m_s;
  logic                flush_e_s;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] ra,
                                         input logic [4:0] rs_m, input logic rw_m,
                                         input logic [4:0] rs_w, input logic rw_w);
    logic [1:0] sel;
    if (rw_m && reg_match(rs_m, ra)) begin
      sel = 2'b10;
    end else if (rw_w && reg_match(rs_w, ra)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign lu_s       = REG_WRITE_E && MEM_TO_REG_E &&
                      (reg_match(RS_E, RA1_D) || reg_match(RS_E, RA2_D));
  assign mem_pend_s = MEM_REQ_M && !MEM_READY;

  // Forwarding selects, forced to the register file while in reset.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (RST_N) begin
      fwd_a_s = fwd_sel(RA1_E, RS_M, REG_WRITE_M, RS_W, REG_WRITE_W);
      fwd_b_s = fwd_sel(RA2_E, RS_M, REG_WRITE_M, RS_W, REG_WRITE_W);
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
  end

  // Next-state, watchdog counter and stall/flush decode.
  always_comb begin
    next_state_s   = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    stall_f_s      = 1'b0;
    stall_d_s      = 1'b0;
    stall_e_s      = 1'b0;
    stall_m_s      = 1'b0;
    flush_e_s      = 1'b0;
    if (!RST_N) begin
      next_state_s   = ST_RUN;
      wait_cnt_nxt_s = {WCNT_W{1'b0}};
      flush_e_s      = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_pend_s) begin
            {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
            next_state_s   = ST_MEM_WAIT;
            wait_cnt_nxt_s = WCNT_W'(1);
          end else if (lu_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
          end else begin
            wait_cnt_nxt_s = {WCNT_W{1'b0}};
          end
        end
        ST_MEM_WAIT: begin
          // Memory completion releases the pipeline in the same cycle.
          if (MEM_READY) begin
            next_state_s   = ST_RUN;
            wait_cnt_nxt_s = {WCNT_W{1'b0}};
            if (lu_s) begin
              stall_f_s = 1'b1;
              stall_d_s = 1'b1;
              flush_e_s = 1'b1;
            end else begin
              flush_e_s = 1'b0;
            end
          end else begin
            {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
            if (wait_cnt_r == WCNT_W'(MAX_WAIT)) begin
              next_state_s = ST_ERROR;
            end else begin
              wait_cnt_nxt_s = wait_cnt_r + WCNT_W'(1);
            end
          end
        end
        ST_ERROR: begin
          {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
        end
        default: begin
          next_state_s   = ST_RUN;
          wait_cnt_nxt_s = {WCNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, watchdog, sticky error and saturating stall counter registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= {WCNT_W{1'b0}};
      err_r       <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      err_r      <= (next_state_s == ST_ERROR);
      if (stall_d_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign FORWARD_A_E  = fwd_a_s;
  assign FORWARD_B_E  = fwd_b_s;
  assign STALL_F      = stall_f_s;
  assign STALL_D      = stall_d_s;
  assign STALL_E      = stall_e_s;
  assign STALL_M      = stall_m_s;
  assign FLUSH_E      = flush_e_s;
  assign ERR          = err_r;
  assign STALL_CYCLES = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a rule-level reference model checked every cycle.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [4:0] RA1_D = 5'd0, RA2_D = 5'd0, RA1_E = 5'd0, RA2_E = 5'd0;
  logic [4:0] RS_E = 5'd0, RS_M = 5'd0, RS_W = 5'd0;
  logic REG_WRITE_E = 1'b0, MEM_TO_REG_E = 1'b0, REG_WRITE_M = 1'b0;
  logic MEM_REQ_M = 1'b0, MEM_READY = 1'b0, REG_WRITE_W = 1'b0;
  logic [1:0] FORWARD_A_E, FORWARD_B_E;
  logic STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_E, ERR;
  logic [CNT_W-1:0] STALL_CYCLES;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: consecutive memory-blocked cycles, sticky error, stall count.
  int m_pend = 0;
  bit m_err = 1'b0;
  int m_cnt = 0;
  bit m_valid = 1'b0;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RA1_D(RA1_D), .RA2_D(RA2_D), .RA1_E(RA1_E), .RA2_E(RA2_E),
    .RS_E(RS_E), .REG_WRITE_E(REG_WRITE_E), .MEM_TO_REG_E(MEM_TO_REG_E),
    .RS_M(RS_M), .REG_WRITE_M(REG_WRITE_M), .MEM_REQ_M(MEM_REQ_M),
    .MEM_READY(MEM_READY), .RS_W(RS_W), .REG_WRITE_W(REG_WRITE_W),
    .FORWARD_A_E(FORWARD_A_E), .FORWARD_B_E(FORWARD_B_E),
    .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E), .STALL_M(STALL_M),
    .FLUSH_E(FLUSH_E), .ERR(ERR), .STALL_CYCLES(STALL_CYCLES)
  );

  always #5 CLK = ~CLK;

  function automatic logic [1:0] exp_fwd(input logic [4:0] ra);
    if (REG_WRITE_M && RS_M != 5'd0 && RS_M == ra) return 2'b10;
    if (REG_WRITE_W && RS_W != 5'd0 && RS_W == ra) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_e}.
  function automatic logic [8:0] exp_ctl();
    logic lu, blocked;
    if (!RST_N) return 9'b0000_0000_1;
    lu = REG_WRITE_E && MEM_TO_REG_E && RS_E != 5'd0 && (RS_E == RA1_D || RS_E == RA2_D);
    if (m_err)           blocked = 1'b1;
    else if (m_pend > 0) blocked = !MEM_READY;
    else                 blocked = MEM_REQ_M && !MEM_READY;
    if (blocked) return {exp_fwd(RA1_E), exp_fwd(RA2_E), 5'b11110};
    if (lu)      return {exp_fwd(RA1_E), exp_fwd(RA2_E), 5'b11001};
    return {exp_fwd(RA1_E), exp_fwd(RA2_E), 5'b00000};
  endfunction

  always @(posedge CLK) begin
    logic [8:0] c;
    c = exp_ctl();
    if (!RST_N) begin
      m_pend = 0; m_err = 1'b0; m_cnt = 0; m_valid = 1'b1;
    end else begin
      if (c[3] && m_cnt < SAT) m_cnt = m_cnt + 1;
      if (!m_err) begin
        if (c[2]) begin
          m_pend = m_pend + 1;
          if (m_pend > MAX_WAIT) m_err = 1'b1;
        end else begin
          m_pend = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    logic [12:0] got, want;
    if (m_valid) begin
      got  = {FORWARD_A_E, FORWARD_B_E, STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_E, ERR, STALL_CYCLES};
      want = {exp_ctl(), m_err, CNT_W'(m_cnt)};
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL model_cycle t=%0t got=%b want=%b", $time, got, want);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  task automatic clear_in();
    {RA1_D, RA2_D, RA1_E, RA2_E, RS_E, RS_M, RS_W} = '0;
    {REG_WRITE_E, MEM_TO_REG_E, REG_WRITE_M, MEM_REQ_M, MEM_READY, REG_WRITE_W} = '0;
  endtask

  task automatic set_lu();
    RS_E = 5'd5; MEM_TO_REG_E = 1'b1; REG_WRITE_E = 1'b1; RA2_D = 5'd5;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; tick();
    RST_N = 1'b1;
  endtask

  initial begin
    tick();
    @(negedge CLK);
    chk("rst_flush", 16'(FLUSH_E), 16'd1);
    chk("rst_stalls", 16'({STALL_F, STALL_D, STALL_E, STALL_M}), 16'd0);
    chk("rst_err_cnt", 16'({ERR, STALL_CYCLES}), 16'd0);
    tick(); RST_N = 1'b1;

    RA1_E = 5'd3; RS_M = 5'd3; REG_WRITE_M = 1'b1; RS_W = 5'd3; REG_WRITE_W = 1'b1;
    @(negedge CLK); chk("fwd_a_mem", 16'(FORWARD_A_E), 16'd2);
    tick(); REG_WRITE_M = 1'b0; RA2_E = 5'd3;
    @(negedge CLK); chk("fwd_a_wb", 16'(FORWARD_A_E), 16'd1);
    chk("fwd_b_wb", 16'(FORWARD_B_E), 16'd1);
    tick(); RS_W = 5'd0; RA1_E = 5'd0; RA2_E = 5'd0;
    @(negedge CLK); chk("fwd_r0", 16'({FORWARD_A_E, FORWARD_B_E}), 16'd0);

    tick(); clear_in(); set_lu();
    @(negedge CLK); chk("lu_bubble", 16'({STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_E}), 16'b11001);
    tick(); RS_E = 5'd0;
    @(negedge CLK); chk("lu_r0_none", 16'({STALL_F, STALL_D, FLUSH_E}), 16'd0);
    chk("lu_count", 16'(STALL_CYCLES), 16'd1);

    tick(); clear_in(); do_reset();
    MEM_REQ_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); chk("wait_stall", 16'({STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_E}), 16'b11110);
      tick();
    end
    MEM_READY = 1'b1;
    @(negedge CLK); chk("wait_ready", 16'({STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_E}), 16'd0);
    tick(); clear_in();
    @(negedge CLK); chk("wait_count", 16'(STALL_CYCLES), 16'd3);

    tick(); set_lu(); MEM_REQ_M = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); chk("wait_lu_hold", 16'({STALL_E, FLUSH_E}), 16'b10);
      tick();
    end
    MEM_READY = 1'b1;
    @(negedge CLK); chk("wait_lu_bubble", 16'({STALL_D, STALL_E, FLUSH_E}), 16'b101);
    tick(); clear_in();
    @(negedge CLK); chk("wait_lu_count", 16'(STALL_CYCLES), 16'd6);

    tick(); set_lu();
    for (int i = 0; i < 10; i++) tick();
    clear_in();
    @(negedge CLK); chk("sat_count", 16'(STALL_CYCLES), 16'd7);

    tick(); do_reset();
    MEM_REQ_M = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); chk("err_not_yet", 16'({ERR, STALL_D}), 16'b01);
      tick();
    end
    @(negedge CLK); chk("err_set", 16'(ERR), 16'd1);
    tick(); MEM_READY = 1'b1;
    @(negedge CLK); chk("err_ignores_ready", 16'({ERR, STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_E}), 16'b111110);
    tick(); RST_N = 1'b0;
    @(negedge CLK); chk("err_rst_forced", 16'({STALL_D, FLUSH_E}), 16'b01);
    tick(); RST_N = 1'b1; clear_in();
    @(negedge CLK); chk("err_cleared", 16'({ERR, STALL_D, STALL_CYCLES}), 16'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Consumes the execute-stage outputs of the decode/execute pipeline register (source/destination addresses, write and load flags) plus the memory and writeback destinations.
- Produces forwarding selects and the stall/flush controls that drive the stage registers; FLUSH_E drives CLR of the decode/execute register.
- Adds a memory-wait state machine with watchdog and a stall-cycle performance counter.

Parameters:
- MAX_WAIT, 16, memory-wait cycles tolerated before a timeout error (>=1).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- CLK  in  1  clock; state updates on posedge.
- RST_N  in  1  synchronous active-low reset.
- RA1_D  in  5  decode-stage source register 1.
- RA2_D  in  5  decode-stage source register 2.
- RA1_E  in  5  execute-stage source register 1.
- RA2_E  in  5  execute-stage source register 2.
- RS_E  in  5  execute-stage destination register.
- REG_WRITE_E  in  1  execute-stage instruction writes a register.
- MEM_TO_REG_E  in  1  execute-stage instruction is a load.
- RS_M  in  5  memory-stage destination register.
- REG_WRITE_M  in  1  memory-stage register write.
- MEM_REQ_M  in  1  memory-stage load or store active.
- MEM_READY  in  1  data memory completes the current access this cycle.
- RS_W  in  5  writeback-stage destination register.
- REG_WRITE_W  in  1  writeback-stage register write.
- FORWARD_A_E  out  2  ALU operand A select: 00 register file, 01 writeback, 10 memory.
- FORWARD_B_E  out  2  ALU operand B select, same encoding.
- STALL_F  out  1  hold PC.
- STALL_D  out  1  hold fetch/decode register.
- STALL_E  out  1  hold decode/execute register.
- STALL_M  out  1  hold execute/memory register.
- FLUSH_E  out  1  clear decode/execute register (bubble).
- ERR  out  1  sticky memory timeout.
- STALL_CYCLES  out  CNT_W  saturating count of cycles with STALL_D=1.

Behaviour:
- Reset (RST_N=0 at posedge):
  - state=RUN, wait counter=0, ERR=0, STALL_CYCLES=0.
  - While RST_N=0, outputs are forced: FLUSH_E=1, all stalls=0, forwards=00.
- Register 0 never matches in any forwarding or hazard comparison.
- Forwarding (combinational):
  - FORWARD_A_E=10 if REG_WRITE_M and RS_M==RA1_E.
  - Else 01 if REG_WRITE_W and RS_W==RA1_E.
  - Else 00.
  - FORWARD_B_E follows the same rules using RA2_E.
  - Memory stage has priority over writeback.
- Load-use hazard: LU = REG_WRITE_E & MEM_TO_REG_E & (RS_E==RA1_D | RS_E==RA2_D).
- States:
  - RUN:
    - If MEM_REQ_M & !MEM_READY: assert STALL_F/D/E/M this cycle, FLUSH_E=0, next state=MEM_WAIT, wait counter=1.
    - Else if LU: STALL_F=STALL_D=1, FLUSH_E=1, STALL_E=STALL_M=0. This is a single-cycle bubble with no state change.
    - Else all outputs 0.
  - MEM_WAIT:
    - All four stalls=1, FLUSH_E=0.
    - MEM_READY=1: stalls deassert in the same cycle (combinational), next state=RUN, counter cleared. LU is evaluated in that cycle as in RUN.
    - Else if counter==MAX_WAIT: next state=ERROR.
    - Else counter+1.
  - ERROR:
    - All stalls=1, FLUSH_E=0, ERR=1.
    - Held until reset; MEM_READY is ignored.
- Simultaneous memory wait and LU: memory wait dominates. FLUSH_E=0 so the execute stage is held, not bubbled.
- STALL_CYCLES: +1 at each posedge where STALL_D=1; saturates at all-ones and does not wrap.
- Mid-operation reset: reset wins over every state, including ERROR; next cycle starts in RUN.

Test Plan:
- RA1_E=3, RS_M=3, REG_WRITE_M=1, RS_W=3, REG_WRITE_W=1 -> FORWARD_A_E=10. Then REG_WRITE_M=0 -> 01. Then RS_W=0, RA1_E=0 -> 00.
- Load in E (RS_E=5, MEM_TO_REG_E=1, REG_WRITE_E=1) with RA2_D=5 -> one cycle STALL_F=STALL_D=FLUSH_E=1, STALL_E=0, STALL_CYCLES increments by 1. RS_E=0 -> no stall.
- MEM_REQ_M=1, MEM_READY=0 for 3 cycles, then 1 -> all stalls high for exactly 3 cycles, low in the ready cycle, FLUSH_E=0 throughout, STALL_CYCLES=3.
- MAX_WAIT=4, MEM_READY held 0 -> ERR rises after the counter reaches 4. Stalls stay high, MEM_READY=1 ignored. RST_N=0 for one posedge -> ERR=0, state RUN.
- Memory wait concurrent with LU -> FLUSH_E=0 during the wait. After MEM_READY, the LU bubble occurs in that same cycle: FLUSH_E=1, STALL_D=1.
- CNT_W=3, force 10 stall cycles -> STALL_CYCLES saturates at 7.
